// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART (TX FIFO + serializer, baud divisor, optional RX).
// Ports: clk, reset (sync, active-low), MemWrite/ALUResult/WriteData (core store bus),
//   ReadData/hit (combinational read path), tx (serial out), rx (serial in).
// Optional RX deserializer and its STATUS bits are compiled in with `define UART_RX_EN.
module uart_mmio #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter logic [15:0] CLKS_PER_BIT = 16'd434,
   parameter int          TX_DEPTH     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        hit,
   output logic        tx,
   input  logic        rx
);

   localparam int AW = $clog2(TX_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_t;

   logic [1:0] idx;
   logic       wr, wr_tx, wr_rx, wr_st, wr_bd;

   assign hit   = ALUResult[31:4] == BASE_ADDR[31:4];
   assign idx   = ALUResult[3:2];
   assign wr    = MemWrite & hit;
   assign wr_tx = wr & (idx == 2'd0);
   assign wr_rx = wr & (idx == 2'd1);
   assign wr_st = wr & (idx == 2'd2);
   assign wr_bd = wr & (idx == 2'd3);

   logic unused_bits;
   assign unused_bits = ^{ALUResult[1:0], WriteData[31:16]};

   // baud divisor, clamped so half-bit timing never collapses
   logic [15:0] baud;
   always_ff @(posedge clk) begin
      if (!reset)
         baud <= CLKS_PER_BIT;
      else if (wr_bd)
         baud <= (WriteData[15:0] < 16'd4) ? 16'd4 : WriteData[15:0];
   end

   // TX FIFO, extra pointer bit distinguishes full from empty
   logic [7:0]  mem [TX_DEPTH];
   logic [AW:0] wp, rp;
   logic        full, empty, push, pop;
   logic [7:0]  head;

   assign empty = wp == rp;
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign push  = wr_tx & ~full;
   assign head  = mem[rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push)
         mem[wp[AW-1:0]] <= WriteData[7:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push)
            wp <= wp + 1'b1;
         if (pop)
            rp <= rp + 1'b1;
      end
   end

   // TX serializer
   st_t         ts;
   logic [15:0] tcnt, tdiv;
   logic [2:0]  tbit;
   logic [7:0]  tsh;
   logic        tend, busy;

   assign tend = tcnt == tdiv - 16'd1;
   assign busy = ts != S_IDLE;
   assign pop  = ~empty & ((ts == S_IDLE) | ((ts == S_STOP) & tend));

   always_ff @(posedge clk) begin
      if (!reset) begin
         ts   <= S_IDLE;
         tcnt <= '0;
         tdiv <= CLKS_PER_BIT;
         tbit <= '0;
         tsh  <= '0;
         tx   <= 1'b1;
      end else begin
         unique case (ts)
            S_IDLE: begin
               if (pop) begin
                  tsh  <= head;
                  tdiv <= baud;
                  tcnt <= '0;
                  tx   <= 1'b0;
                  ts   <= S_START;
               end
            end
            S_START: begin
               if (tend) begin
                  tcnt <= '0;
                  tbit <= '0;
                  tx   <= tsh[0];
                  tsh  <= tsh >> 1;
                  ts   <= S_DATA;
               end else
                  tcnt <= tcnt + 16'd1;
            end
            S_DATA: begin
               if (tend) begin
                  tcnt <= '0;
                  if (tbit == 3'd7) begin
                     tx <= 1'b1;
                     ts <= S_STOP;
                  end else begin
                     tx   <= tsh[0];
                     tsh  <= tsh >> 1;
                     tbit <= tbit + 3'd1;
                  end
               end else
                  tcnt <= tcnt + 16'd1;
            end
            S_STOP: begin
               if (tend) begin
                  tcnt <= '0;
                  // chain straight into the next frame when data waits
                  if (pop) begin
                     tsh  <= head;
                     tdiv <= baud;
                     tx   <= 1'b0;
                     ts   <= S_START;
                  end else
                     ts <= S_IDLE;
               end else
                  tcnt <= tcnt + 16'd1;
            end
            default: ts <= S_IDLE;
         endcase
      end
   end

   logic [7:0] rx_byte;
   logic       rx_valid, rx_ovr, rx_ferr;

`ifdef UART_RX_EN
   logic        rs1, rs2;
   st_t         rs;
   logic [15:0] rcnt, rdiv;
   logic [2:0]  rbit;
   logic [7:0]  rsh;
   logic        rhalf, rend, rok, rbad;

   assign rhalf = rcnt == (rdiv >> 1) - 16'd1;
   assign rend  = rcnt == rdiv - 16'd1;
   assign rok   = (rs == S_STOP) & rend & rs2;
   assign rbad  = (rs == S_STOP) & rend & ~rs2;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rs1 <= 1'b1;
         rs2 <= 1'b1;
      end else begin
         rs1 <= rx;
         rs2 <= rs1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rs      <= S_IDLE;
         rcnt    <= '0;
         rdiv    <= CLKS_PER_BIT;
         rbit    <= '0;
         rsh     <= '0;
         rx_byte <= '0;
      end else begin
         unique case (rs)
            S_IDLE: begin
               if (!rs2) begin
                  rdiv <= baud;
                  rcnt <= '0;
                  rs   <= S_START;
               end
            end
            S_START: begin
               if (rhalf) begin
                  rcnt <= '0;
                  rbit <= '0;
                  // still high at mid-start: a glitch, not a frame
                  rs   <= rs2 ? S_IDLE : S_DATA;
               end else
                  rcnt <= rcnt + 16'd1;
            end
            S_DATA: begin
               if (rend) begin
                  rcnt <= '0;
                  rsh  <= {rs2, rsh[7:1]};
                  if (rbit == 3'd7)
                     rs <= S_STOP;
                  else
                     rbit <= rbit + 3'd1;
               end else
                  rcnt <= rcnt + 16'd1;
            end
            S_STOP: begin
               if (rend) begin
                  rcnt <= '0;
                  if (rs2)
                     rx_byte <= rsh;
                  rs <= S_IDLE;
               end else
                  rcnt <= rcnt + 16'd1;
            end
            default: rs <= S_IDLE;
         endcase
      end
   end

   // a completing byte beats a concurrent clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_valid <= 1'b0;
         rx_ovr   <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_valid <= rok | (rx_valid & ~wr_rx);
         rx_ovr   <= (rok & rx_valid & ~wr_rx)
                   | (rx_ovr & ~(wr_st & WriteData[4]));
         rx_ferr  <= rbad | (rx_ferr & ~(wr_st & WriteData[5]));
      end
   end
`else
   logic unused_rx;
   assign unused_rx = rx ^ wr_rx ^ wr_st;
   assign rx_byte   = '0;
   assign rx_valid  = 1'b0;
   assign rx_ovr    = 1'b0;
   assign rx_ferr   = 1'b0;
`endif

   logic [31:0] rdata;
   always_comb begin
      rdata = '0;
      unique case (idx)
         2'd0: rdata = '0;
         2'd1: rdata = {24'b0, rx_byte};
         2'd2: rdata = {26'b0, rx_ferr, rx_ovr, rx_valid, busy, empty, full};
         2'd3: rdata = {16'b0, baud};
         default: rdata = '0;
      endcase
   end

   assign ReadData = hit ? rdata : '0;

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for uart_mmio.
// Register reads and TX frames are queued as expectations and checked by monitors.
module tb_uart_mmio;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] ALUResult = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic        hit;
   logic        tx;
   logic        rx = 1'b1;

   always #5 clk = ~clk;

   uart_mmio dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .hit       (hit),
      .tx        (tx),
      .rx        (rx)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int rd_tick = 0;
   int mon_div = 4;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       nm;
      logic [31:0] data;
      logic        hitv;
      bit          tx_chk;
      logic        txv;
   } rd_t;

   typedef struct {
      logic [7:0] b;
      int         start;
   } fr_t;

   rd_t rq[$];
   fr_t fq[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic rd(string nm, logic [31:0] a, logic [31:0] d, logic h);
      @(negedge clk);
      MemWrite  = 1'b0;
      ALUResult = a;
      rq.push_back('{nm, d, h, 1'b0, 1'b1});
      #1 rd_tick++;
   endtask

   task automatic chk_tx(string nm, logic v);
      @(negedge clk);
      rq.push_back('{nm, 32'h0, 1'b0, 1'b1, v});
      #1 rd_tick++;
   endtask

   task automatic wr(logic [31:0] a, logic [31:0] d, output int edge_n);
      @(negedge clk);
      ALUResult = a;
      WriteData = d;
      MemWrite  = 1'b1;
      @(posedge clk);
      #1;
      edge_n   = cyc;
      MemWrite = 1'b0;
   endtask

   task automatic wait_tx(int limit);
      int t;
      t = 0;
      while (fq.size() > 0 && t < limit) begin
         @(posedge clk);
         t++;
      end
      n_cmp++;
      if (fq.size() != 0) begin
         n_bad++;
         $display("FAIL tx_timeout: got %0d pending expected 0", fq.size());
      end
   endtask

   // read-path monitor
   initial begin
      rd_t r;
      forever begin
         @(rd_tick);
         if (rq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_queue: got empty expected entry");
         end else begin
            r = rq.pop_front();
            if (r.tx_chk)
               chk(r.nm, {31'b0, tx}, {31'b0, r.txv});
            else begin
               chk({r.nm, ".data"}, ReadData, r.data);
               chk({r.nm, ".hit"}, {31'b0, hit}, {31'b0, r.hitv});
            end
         end
      end
   end

   // serial-line monitor: decodes frames at mid-bit
   initial begin
      logic [9:0] bits;
      fr_t        f;
      int         st;
      bit         ab;
      forever begin
         @(posedge clk);
         #1;
         if (reset && tx === 1'b0) begin
            st = cyc;
            ab = 1'b0;
            bits = '0;
            for (int k = 0; k < 10; k++) begin
               repeat (k == 0 ? mon_div / 2 : mon_div) @(posedge clk);
               #1;
               if (!reset) begin
                  ab = 1'b1;
                  break;
               end
               bits[k] = tx;
            end
            if (!ab) begin
               chk("tx.start_bit", {31'b0, bits[0]}, 32'h0);
               chk("tx.stop_bit", {31'b0, bits[9]}, 32'h1);
               if (fq.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL tx.unexpected: got 0x%0h expected none",
                           bits[8:1]);
               end else begin
                  f = fq.pop_front();
                  chk("tx.byte", {24'b0, bits[8:1]}, {24'b0, f.b});
                  chk("tx.start_cyc", st, f.start);
               end
               repeat (mon_div - mon_div / 2 - 1) @(posedge clk);
            end
         end
      end
   end

`ifdef UART_RX_EN
   task automatic send_rx(logic [7:0] b, logic stopb);
      @(negedge clk);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (4) @(negedge clk);
      end
      rx = stopb;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (8) @(negedge clk);
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, n0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      rd("status_rst", 32'h1008, 32'h02, 1'b1);
      chk_tx("tx_rst", 1'b1);
      rd("baud_rst", 32'h100C, 32'd434, 1'b1);
      rd("miss", 32'h2000, 32'h0, 1'b0);

      wr(32'h100C, 32'd4, n);
      wr(32'h1000, 32'h55, n);
      fq.push_back('{8'h55, n + 1});
      wait_tx(200);
      repeat (4) @(posedge clk);
      rd("status_after_55", 32'h1008, 32'h02, 1'b1);

      n0 = 0;
      for (int i = 1; i <= 6; i++) begin
         wr(32'h1000, i, n);
         if (i == 1)
            n0 = n;
         if (i <= 5)
            fq.push_back('{i[7:0], n0 + 1 + 40 * (i - 1)});
      end
      rd("status_full", 32'h1008, 32'h05, 1'b1);
      wait_tx(400);
      repeat (4) @(posedge clk);
      rd("status_drained", 32'h1008, 32'h02, 1'b1);

`ifdef UART_RX_EN
      send_rx(8'hA3, 1'b1);
      rd("rx_st_a3", 32'h1008, 32'h0A, 1'b1);
      rd("rx_data_a3", 32'h1004, 32'hA3, 1'b1);
      send_rx(8'h5C, 1'b1);
      rd("rx_st_ovr", 32'h1008, 32'h1A, 1'b1);
      rd("rx_data_5c", 32'h1004, 32'h5C, 1'b1);
      wr(32'h1008, 32'h10, n);
      rd("rx_st_ovr_clr", 32'h1008, 32'h0A, 1'b1);
      send_rx(8'h33, 1'b0);
      rd("rx_st_ferr", 32'h1008, 32'h2A, 1'b1);
      rd("rx_data_keep", 32'h1004, 32'h5C, 1'b1);
      wr(32'h1008, 32'h20, n);
      wr(32'h1004, 32'h0, n);
      rd("rx_st_clr", 32'h1008, 32'h02, 1'b1);
      @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (12) @(negedge clk);
      rd("rx_glitch", 32'h1008, 32'h02, 1'b1);
`endif

      wr(32'h100C, 32'd2, n);
      rd("baud_clamp", 32'h100C, 32'd4, 1'b1);
      wr(32'h100C, 32'h0001_2345, n);
      rd("baud_upper", 32'h100F, 32'h2345, 1'b1);
      wr(32'h100C, 32'd4, n);
      rd("txdata_rd", 32'h1000, 32'h0, 1'b1);

      wr(32'h1000, 32'hAA, n);
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk_tx("tx_abort", 1'b1);
      rd("status_abort", 32'h1008, 32'h02, 1'b1);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      rd("baud_abort", 32'h100C, 32'd434, 1'b1);
      repeat (20) @(posedge clk);
      chk_tx("tx_idle_end", 1'b1);
      repeat (2) @(posedge clk);
      chk("fq_empty", fq.size(), 0);
      chk("rq_empty", rq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
